// File: rtl/uart_tx_sender.sv
// Serialising UART transmitter: start bit, 8 data bits LSB first, optional parity,
// 1 or 2 stop bits. TX_STATUS is high while idle and ready to accept a byte.
module uart_tx_sender #(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD_RATE = 9600,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic [7:0] TX_DATA,
  input  logic       TX_EN,
  output logic       TX_STATUS,
  output logic       UART_TX
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam bit HAS_PARITY = (PARITY != 0);
  localparam bit TWO_STOP   = (STOP_BITS == 2);

  // Reject configurations the bit timing or framing cannot represent.
  generate
    if (CLKS_PER_BIT < 2 || PARITY > 2 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_cfg
      $error("uart_tx_sender: unsupported CLKS_PER_BIT, PARITY or STOP_BITS");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       data_q;
  logic             parity_bit;
  logic             stop_idx;
  logic             bit_done_c;
  logic             par_c;

  assign bit_done_c = (baud_cnt == LAST_CNT);
  assign par_c      = (PARITY == 1) ? ~^TX_DATA : ^TX_DATA;

  // Frame sequencer; every output and the next bit value are registered here.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      data_q     <= '0;
      parity_bit <= 1'b0;
      stop_idx   <= 1'b0;
      TX_STATUS  <= 1'b1;
      UART_TX    <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (TX_EN) begin
            data_q     <= TX_DATA;
            parity_bit <= par_c;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            state      <= S_START;
            TX_STATUS  <= 1'b0;
            UART_TX    <= 1'b0;
          end
        end

        S_START: begin
          if (bit_done_c) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= S_DATA;
            UART_TX  <= data_q[0];
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        S_DATA: begin
          if (bit_done_c) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              if (HAS_PARITY) begin
                state   <= S_PARITY;
                UART_TX <= parity_bit;
              end else begin
                state    <= S_STOP;
                stop_idx <= 1'b0;
                UART_TX  <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              UART_TX <= data_q[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        S_PARITY: begin
          if (bit_done_c) begin
            baud_cnt <= '0;
            stop_idx <= 1'b0;
            state    <= S_STOP;
            UART_TX  <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        S_STOP: begin
          if (bit_done_c) begin
            baud_cnt <= '0;
            if (TWO_STOP && !stop_idx) begin
              stop_idx <= 1'b1;
            end else if (TX_EN) begin
              // Request on the final stop edge starts the next frame with no idle gap.
              data_q     <= TX_DATA;
              parity_bit <= par_c;
              bit_idx    <= '0;
              stop_idx   <= 1'b0;
              state      <= S_START;
              TX_STATUS  <= 1'b0;
              UART_TX    <= 1'b0;
            end else begin
              stop_idx  <= 1'b0;
              state     <= S_IDLE;
              TX_STATUS <= 1'b1;
              UART_TX   <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        default: begin
          state     <= S_IDLE;
          baud_cnt  <= '0;
          TX_STATUS <= 1'b1;
          UART_TX   <= 1'b1;
        end
      endcase
    end
  end

endmodule
